// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle between ALU control, the execute ALU and its consumer.
// The master side issues requests and takes results; the slave side is the ALU.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      operation;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal_op;

    modport master (
        output in_valid, operation, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal_op
    );

    modport slave (
        input  in_valid, operation, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal_op
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute ALU: AND/OR/ADD/SUB (and SLT under ALU_SLT_EN) in 1 cycle, SLL bit-serial in shamt+1.
// Accepts only in IDLE; the result is held in DONE until the consumer takes it.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
`ifdef ALU_SLT_EN
    localparam logic [3:0] OP_SLT = 4'b0111;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [XLEN-1:0]    r_shift;
    logic [SHAMT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_result;
    logic               r_zero;
    logic               r_illegal;

    logic [XLEN-1:0]    w_res;
    logic               w_illegal;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept;
    logic               w_to_shift;
    logic [XLEN-1:0]    w_shift_nxt;
    logic               w_shift_last;

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.result     = r_result;
    assign bus.zero       = r_zero;
    assign bus.illegal_op = r_illegal;

    assign w_shamt      = bus.op_b[SHAMT_W-1:0];
    assign w_accept     = bus.in_valid && (r_state == IDLE);
    assign w_to_shift   = (bus.operation == OP_SLL) && (w_shamt != '0);
    assign w_shift_nxt  = {r_shift[XLEN-2:0], 1'b0};
    assign w_shift_last = (r_cnt == SHAMT_W'(1));

    // Single-cycle result; SLL by zero falls through as a plain copy of op_a.
    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (bus.operation)
            OP_AND:  w_res = bus.op_a & bus.op_b;
            OP_OR:   w_res = bus.op_a | bus.op_b;
            OP_ADD:  w_res = bus.op_a + bus.op_b;
            OP_SUB:  w_res = bus.op_a - bus.op_b;
            OP_SLL:  w_res = bus.op_a;
`ifdef ALU_SLT_EN
            OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_to_shift ? SHIFT : DONE;
            SHIFT:   if (w_shift_last) w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_shift <= bus.op_a;
            r_cnt   <= w_shamt;
            if (!w_to_shift) begin
                r_result  <= w_res;
                r_zero    <= (w_res == '0);
                r_illegal <= w_illegal;
            end
        end else if (r_state == SHIFT) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt - 1'b1;
            // Last shift lands straight in the output register so DONE sees it at once.
            if (w_shift_last) begin
                r_result  <= w_shift_nxt;
                r_zero    <= (w_shift_nxt == '0);
                r_illegal <= 1'b0;
            end
        end
    end
endmodule
